// File: rtl/alu_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// alu_pipe_ctrl
//   Sequential ALU with valid/ready handshakes on both sides. Single-cycle ops
//   (add, sub, and, or, shifts) are computed on the accepting edge. MUL runs a
//   WIDTH-cycle shift-add loop over a 2*WIDTH accumulator. The result and flags
//   are held stable in DONE until the consumer takes them.
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   in_valid   operand/op bundle valid          in_ready  block can accept
//   x, y       operands A and B (WIDTH)
//   shamt      unsigned shift amount (SHIFT)
//   operation  opcode (3 bits)
//   out_valid  result/flags valid               out_ready consumer accepts
//   result     registered result (WIDTH)
//   zero       result == 0
//   carry      add carry-out / sub no-borrow / mul high half nonzero
//   overflow   signed overflow for add/sub
//   busy       FSM not in IDLE
//   state_dbg  current FSM state encoding (IDLE=0, EXEC=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
//   high. in_valid is ignored outside IDLE; operands may change after the
//   accepting edge. out_valid stays high, with result/flags frozen, until
//   out_ready is seen high on an edge.
// -----------------------------------------------------------------------------
module alu_pipe_ctrl #(
  parameter int WIDTH = 8,
  parameter int SHIFT = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [SHIFT-1:0] shamt,
  input  logic [2:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Multiply operands are captured so the source may move on after acceptance.
  logic [WIDTH-1:0]   x_q, y_q;
  logic [2*WIDTH-1:0] acc, acc_add, acc_nxt;
  logic [CW-1:0]      cnt;
  logic               mul_last;

  // Single-cycle datapath
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  logic               accept;

  // in_ready is gated by reset so it reads 0 while reset is held low.
  assign in_ready  = reset && (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;
  assign accept    = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Single-cycle ALU. Native SV shifts already return 0 (or sign fill for >>>)
  // when the amount reaches WIDTH, which covers the large-shamt boundary.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum     = {1'b0, x} + {1'b0, y};
    diff    = x - y;
    case (operation)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (x[MSB] == y[MSB]) && (sum[MSB] != x[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = (x >= y);
        alu_v   = (x[MSB] != y[MSB]) && (diff[MSB] != x[MSB]);
      end
      OP_AND: alu_res = x & y;
      OP_OR:  alu_res = x | y;
      OP_SLL: alu_res = x << shamt;
      OP_SRL: alu_res = x >> shamt;
      OP_SRA: alu_res = $signed(x) >>> shamt;
      default: alu_res = '0;  // MUL is handled by the EXEC loop
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift-add multiply step: bit cnt of y selects x << cnt.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_add  = {{WIDTH{1'b0}}, x_q} << cnt;
    acc_nxt  = y_q[cnt] ? (acc + acc_add) : acc;
    mul_last = (cnt == CW'(WIDTH - 1));
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (operation == OP_MUL) ? ST_EXEC : ST_DONE;
      ST_EXEC: if (mul_last) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. result/flags load only on the edge that enters DONE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else if (accept) begin
      if (operation == OP_MUL) begin
        x_q <= x;
        y_q <= y;
        acc <= '0;
        cnt <= '0;
      end else begin
        result   <= alu_res;
        zero     <= (alu_res == '0);
        carry    <= alu_c;
        overflow <= alu_v;
      end
    end else if (state == ST_EXEC) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (mul_last) begin
        result   <= acc_nxt[WIDTH-1:0];
        zero     <= (acc_nxt[WIDTH-1:0] == '0);
        carry    <= |acc_nxt[2*WIDTH-1:WIDTH];
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe_ctrl
//   Directed vector table plus random ops, checked through an expected queue,
//   and hand-written sequences for MUL timing, backpressure and mid-op reset.
// -----------------------------------------------------------------------------
module tb_alu_pipe_ctrl;

  localparam int W  = 8;
  localparam int SH = 3;
  localparam int EW = W + 3;  // {result, zero, carry, overflow}

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // ---------------- clock / reset ----------------
  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x, y;
  logic [SH-1:0] shamt;
  logic [2:0]    operation;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero, carry, overflow, busy;
  logic [1:0]    state_dbg;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  alu_pipe_ctrl #(.WIDTH(W), .SHIFT(SH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .shamt     (shamt),
    .operation (operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model built on plain integer arithmetic.
  function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [SH-1:0] sh);
    int ia, ib, sa, sb, r, s;
    logic c, v;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    case (op)
      OP_ADD: begin r = ia + ib; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      OP_SUB: begin r = ia - ib; c = (ia >= ib); s = sa - sb; v = (s > 127) || (s < -128); end
      OP_AND: r = ia & ib;
      OP_OR:  r = ia | ib;
      OP_SLL: r = ia << sh;
      OP_SRL: r = ia >> sh;
      OP_SRA: r = sa >>> sh;
      default: begin r = ia * ib; c = (r > 255); end
    endcase
    r = r & 255;
    return {r[7:0], (r[7:0] == 8'h00), c, v};
  endfunction

  // ---------------- driver ----------------
  // Drives one bundle, waits (bounded) for the result, checks latency and the
  // popped expectation, then lets one edge pass for the output transfer.
  // With inject set, an extra in_valid pulse is driven in the 3rd wait cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [SH-1:0] sh,
                        input logic [EW-1:0] exp, input int exp_lat, input bit inject);
    int t;
    int n;
    logic [EW-1:0] got;
    @(negedge clock);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    exp_q.push_back(exp);
    operation = op;
    x         = a;
    y         = b;
    shamt     = sh;
    in_valid  = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    x        = W'($urandom_range(0, 255));
    y        = W'($urandom_range(0, 255));
    shamt    = SH'($urandom_range(0, 7));
    n = 1;
    while (!out_valid && n < 40) begin
      check({tag, "_exec_busy"}, 32'(busy), 32'd1);
      check({tag, "_exec_in_ready"}, 32'(in_ready), 32'd0);
      if (inject && n == 3) begin
        in_valid  = 1'b1;
        operation = OP_ADD;
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    got = exp_q.pop_front();
    if (out_valid) begin
      check({tag, "_result"}, 32'({result, zero, carry, overflow}), 32'(got));
      check({tag, "_busy"}, 32'(busy), 32'd1);
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SH-1:0] sh;
    logic [W-1:0]  res;
    logic          z, c, v;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [2:0]    rop;
    logic [W-1:0]  ra, rb;
    logic [SH-1:0] rs;
    bit            seen_valid;

    vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{OP_SUB, 8'h05, 8'h05, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{OP_SUB, 8'h03, 8'h05, 3'd0, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OP_SRA, 8'h90, 8'h00, 3'd3, 8'hF2, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_SRL, 8'h90, 8'h00, 3'd3, 8'h12, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_SLL, 8'h81, 8'h00, 3'd1, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_SRL, 8'h90, 8'h00, 3'd7, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_SLL, 8'hA5, 8'h00, 3'd0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_AND, 8'hF0, 8'h3C, 3'd5, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_OR,  8'hF0, 8'h0C, 3'd2, 8'hFC, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{OP_ADD, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{OP_SUB, 8'h80, 8'h01, 3'd0, 8'h7F, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{OP_MUL, 8'h12, 8'h10, 3'd0, 8'h20, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{OP_MUL, 8'h0F, 8'h0F, 3'd0, 8'hE1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{OP_SRA, 8'h7F, 8'h00, 3'd7, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{OP_SRA, 8'h80, 8'h00, 3'd7, 8'hFF, 1'b0, 1'b0, 1'b0};

    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    shamt     = '0;
    operation = OP_ADD;

    // ---- reset state ----
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result_flags", 32'({result, zero, carry, overflow}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // ---- directed table ----
    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
             {vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v},
             (vecs[i].op == OP_MUL) ? W + 1 : 1, 1'b0);
    end

    // ---- MUL with an ignored in_valid pulse during EXEC ----
    run_op("mul_inject", OP_MUL, 8'h12, 8'h10, 3'd0, {8'h20, 1'b0, 1'b1, 1'b0}, W + 1, 1'b1);
    check("mul_inject_idle_after", 32'(state_dbg), 32'd0);
    check("mul_inject_no_extra", 32'(out_valid), 32'd0);

    // ---- random ops ----
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom_range(0, 255));
      rb  = W'($urandom_range(0, 255));
      rs  = SH'($urandom_range(0, 7));
      run_op($sformatf("rnd%0d", i), rop, ra, rb, rs, model(rop, ra, rb, rs),
             (rop == OP_MUL) ? W + 1 : 1, 1'b0);
    end

    // ---- backpressure ----
    out_ready = 1'b0;
    run_op("bp", OP_ADD, 8'h7F, 8'h01, 3'd0, {8'h80, 1'b0, 1'b0, 1'b1}, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d_result", i), 32'({result, zero, carry, overflow}),
            32'({8'h80, 1'b0, 1'b0, 1'b1}));
      check($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // ---- reset during the 4th EXEC cycle of a MUL ----
    @(negedge clock);
    operation = OP_MUL;
    x         = 8'h12;
    y         = 8'h10;
    in_valid  = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    check("mr_pre_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_result", 32'(result), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (out_valid) seen_valid = 1'b1;
    end
    check("mr_no_stale_result", 32'(seen_valid), 32'd0);
    run_op("mr_add", OP_ADD, 8'h01, 8'h01, 3'd0, {8'h02, 1'b0, 1'b0, 1'b0}, 1, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so a stuck DUT cannot hang the run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_pipe_ctrl.md
# alu_pipe_ctrl

Parametrised sequential ALU that succeeds the 4-bit switch-driven ALU demo. It operates at any operand width and adds a valid/ready handshake on both sides, registered results, carry/overflow flags, arithmetic shift and a multi-cycle shift-add multiply. It sits between an operand source (register file or board-level front end) and a result consumer, and runs entirely in the `clock` domain.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width in bits; must be at least 2.
- `SHIFT`, 3: shift-amount width in bits; shift range is 0..2^SHIFT-1.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  the operand/op bundle is valid.
- `in_ready`  out  1  the block can accept a bundle.
- `x`  in  WIDTH  operand A.
- `y`  in  WIDTH  operand B.
- `shamt`  in  SHIFT  shift amount, unsigned.
- `operation`  in  3  opcode.
- `out_valid`  out  1  the result and flags are valid.
- `out_ready`  in  1  the consumer accepts the result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `result` == 0.
- `carry`  out  1  carry / no-borrow / multiply high-half nonzero.
- `overflow`  out  1  signed overflow (ADD/SUB only).
- `busy`  out  1  state is not IDLE.

## Operation
- Opcodes:
  - 000 ADD: x+y.
  - 001 SUB: x-y.
  - 010 AND.
  - 011 OR.
  - 100 SLL: x<<shamt.
  - 101 SRL: x>>shamt, logical.
  - 110 SRA: x>>>shamt, arithmetic.
  - 111 MUL: low WIDTH bits of unsigned x*y.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, capture x, y, shamt and operation. Non-MUL ops compute and register result and flags, then go to DONE. MUL clears the 2*WIDTH accumulator and the bit counter, then goes to EXEC.
  - EXEC: each cycle, if the current y bit is 1, add x shifted left by the counter value into the accumulator. Increment the counter. After WIDTH cycles (counter == WIDTH-1 processed), register the low half as `result` and go to DONE.
  - DONE: `out_valid`=1. Hold `result` and all flags stable until `out_ready`=1, then go to IDLE.
- Handshake rules:
  - `in_valid` is ignored outside IDLE.
  - Operand inputs may change freely after acceptance.
  - `out_valid` and `out_ready` in the same cycle completes the transfer.
- Flags:
  - `zero`: valid for all ops.
  - ADD: `carry` = carry out of the MSB. `overflow` = operands share a sign and the result sign differs.
  - SUB: `carry` = 1 when x >= y unsigned (no borrow). `overflow` = operand signs differ and the result sign differs from x.
  - MUL: `carry` = 1 when the upper WIDTH bits of the product are nonzero. `overflow` = 0.
  - Logic and shift ops: `carry` = 0 and `overflow` = 0.
- Shift boundaries:
  - shamt >= WIDTH gives 0 for SLL and SRL.
  - shamt >= WIDTH gives all copies of x[WIDTH-1] for SRA.
  - shamt = 0 passes x through unchanged.
- Arithmetic is modulo 2^WIDTH. The multiply accumulator is 2*WIDTH bits and never wraps.

## Timing
- Reset (asynchronous, effective immediately while `reset`=0):
  - state = IDLE.
  - `result`, `zero`, `carry`, `overflow`, `out_valid`, `busy` = 0.
  - accumulator and counter = 0.
  - `in_ready` is forced to 0 while `reset`=0 and goes to 1 in the first cycle after release.
- Latency, counted from the accepting edge:
  - Non-MUL ops: `out_valid` is high 1 cycle later.
  - MUL: `out_valid` is high WIDTH+1 cycles later (WIDTH EXEC cycles, then DONE).
- Minimum spacing between accepted bundles is 2 cycles for non-MUL ops (IDLE, DONE) with `out_ready` held high.
- `busy` = 1 in EXEC and DONE.
- Reset asserted in EXEC or DONE abandons the operation; no result is presented after release.
- `result` and the flags change only on the edge that enters DONE.

## Test plan
- ADD x=0x7F, y=0x01 -> one cycle after accept: `result`=0x80, `overflow`=1, `carry`=0, `zero`=0, `out_valid`=1.
- SUB 0x05-0x05 -> `result`=0x00, `zero`=1, `carry`=1. SUB 0x03-0x05 -> `result`=0xFE, `carry`=0, `overflow`=0.
- Shifts:
  - SRA 0x90 by 3 -> 0xF2.
  - SRL 0x90 by 3 -> 0x12.
  - SLL 0x81 by 1 -> 0x02.
  - SRL 0x90 by 7 -> 0x01.
  - SLL by 0 -> x unchanged.
- MUL 0x12*0x10 -> `result`=0x20, `carry`=1. `out_valid` rises exactly 9 cycles after accept. `in_ready`=0 and `busy`=1 throughout. A second `in_valid` pulse during EXEC is ignored.
- Backpressure: `out_ready`=0 for 5 cycles in DONE -> `result` and flags stable, `in_ready`=0. On `out_ready`=1, IDLE follows the next cycle and `in_ready`=1.
- Reset pulled low in the 4th EXEC cycle of a MUL -> `out_valid`, `result` and `busy` are 0 immediately. After release, ADD 0x01+0x01 returns 0x02 with the normal 1-cycle latency.
